aes_iter_ctrl: RTL and testbench

AES_ITER_CTRL -- requirements
Module: aes_iter_ctrl

---
 rtl/aes_array.sv | 64 ++++++
 rtl/aes_const.sv | 18 +
 rtl/aes_round.sv | 52 +++++
 rtl/aes_iter_ctrl.sv | 97 +++++++++
 tb/tb_aes_iter_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/aes_array.sv
`default_nettype none
// ====================================================================
// aes_array -- SBox, RCon and GF(2^8) exp/log tables (generator 3).  Rev 1.0
// ====================================================================
package aes_array;

   typedef logic [0:255][7:0] tbl256_t;

   localparam tbl256_t SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Indexed directly by the 4-bit round counter; only entries 1..10 are used.
   localparam logic [0:15][7:0] RCON = {
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic tbl256_t gen_exp3();
      tbl256_t    t;
      logic [7:0] e;
      e = 8'h01;
      for (int i = 0; i < 256; i++) begin
         t[i] = e;
         e    = e ^ xtime(e);
      end
      return t;
   endfunction

   function automatic tbl256_t gen_ln3();
      tbl256_t    t;
      logic [7:0] e;
      t = '0;
      e = 8'h01;
      for (int i = 0; i < 255; i++) begin
         t[e] = 8'(i);
         e    = e ^ xtime(e);
      end
      return t;
   endfunction

   localparam tbl256_t EXP_3 = gen_exp3();
   localparam tbl256_t LN_3  = gen_ln3();

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, LN_3[a]} + {1'b0, LN_3[b]};
      if (s >= 9'd255) s = s - 9'd255;
      return (a == 8'h00 || b == 8'h00) ? 8'h00 : EXP_3[s[7:0]];
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_const.sv
`default_nettype none
// ====================================================================
// aes_const -- AES-128 sizing and controller state encoding.  Rev 1.0
// ====================================================================
package aes_const;

   localparam int NB = 4;
   localparam int NK = 4;
   localparam int NR = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

endpackage
`default_nettype wire

// File: rtl/aes_round.sv
`default_nettype none
// ====================================================================
// aes_round -- one combinational AES round; MixColumns skipped when last.  Rev 1.0
// ====================================================================
module aes_round
   import aes_const::*, aes_array::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] rkey,
   input  logic         last,
   output logic [127:0] state_out
);

   // Element 0 is the most significant byte; byte index = row + 4*column.
   typedef logic [0:15][7:0] blk_t;

   function automatic blk_t aes_sbyte(input blk_t s);
      blk_t o;
      for (int i = 0; i < 16; i++) o[i] = SBOX[s[i]];
      return o;
   endfunction

   function automatic blk_t aes_srow(input blk_t s);
      blk_t o;
      for (int c = 0; c < NB; c++)
         for (int r = 0; r < 4; r++)
            o[r + 4*c] = s[r + 4*((c + r) % NB)];
      return o;
   endfunction

   function automatic blk_t aes_mcol(input blk_t s);
      blk_t o;
      for (int c = 0; c < NB; c++)
         for (int r = 0; r < 4; r++)
            o[4*c + r] = gf_mul(8'h02, s[4*c + r]) ^ gf_mul(8'h03, s[4*c + (r + 1) % 4])
                       ^ s[4*c + (r + 2) % 4] ^ s[4*c + (r + 3) % 4];
      return o;
   endfunction

   function automatic blk_t aes_arkey(input blk_t s, input blk_t k);
      return s ^ k;
   endfunction

   blk_t sub_bytes, shift_rows, mix_cols;

   assign sub_bytes  = aes_sbyte(state_in);
   assign shift_rows = aes_srow(sub_bytes);
   assign mix_cols   = last ? shift_rows : aes_mcol(shift_rows);
   assign state_out  = aes_arkey(mix_cols, rkey);

endmodule
`default_nettype wire

// File: rtl/aes_iter_ctrl.sv
`default_nettype none
// ====================================================================
// aes_iter_ctrl -- iterative AES-128 encryptor, one round per clock.  Rev 1.0
// ====================================================================
module aes_iter_ctrl
   import aes_const::*, aes_array::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] key,
   input  logic [127:0] data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] result,
   output logic         busy
);

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   fsm_t         fsm, fsm_d;
   logic [3:0]   round, round_d;
   logic [127:0] state_reg, state_d, rkey_reg, rkey_d;
   logic [127:0] rkey_next, round_out;
   logic [31:0]  rot_word, sched_word, w0, w1, w2, w3;
   logic         accept, last;

   // Key schedule step: word 3 is the least significant word of the round key.
   assign rot_word   = {rkey_reg[23:0], rkey_reg[31:24]};
   assign sched_word = {SBOX[rot_word[31:24]], SBOX[rot_word[23:16]],
                        SBOX[rot_word[15:8]],  SBOX[rot_word[7:0]]} ^ {RCON[round], 24'h0};
   assign w0         = rkey_reg[127:96] ^ sched_word;
   assign w1         = rkey_reg[95:64]  ^ w0;
   assign w2         = rkey_reg[63:32]  ^ w1;
   assign w3         = rkey_reg[31:0]   ^ w2;
   assign rkey_next  = {w0, w1, w2, w3};

   assign last = (round == LAST_ROUND);

   aes_round u_round (
      .state_in  (state_reg),
      .rkey      (rkey_next),
      .last      (last),
      .state_out (round_out)
   );

   // Reset gates in_ready so nothing appears ready while rst is held low.
   assign in_ready  = (fsm == IDLE) & rst;
   assign accept    = in_valid & (fsm == IDLE);
   assign out_valid = (fsm == DONE);
   assign busy      = (fsm == RUN);
   assign result    = out_valid ? state_reg : '0;

   always_comb begin
      fsm_d   = fsm;
      round_d = round;
      state_d = state_reg;
      rkey_d  = rkey_reg;
      case (fsm)
         IDLE: begin
            if (accept) begin
               state_d = data ^ key;
               rkey_d  = key;
               round_d = 4'd1;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            state_d = round_out;
            rkey_d  = rkey_next;
            if (last) fsm_d = DONE;
            else      round_d = round + 4'd1;
         end
         DONE: begin
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm       <= IDLE;
         round     <= '0;
         state_reg <= '0;
         rkey_reg  <= '0;
      end else begin
         fsm       <= fsm_d;
         round     <= round_d;
         state_reg <= state_d;
         rkey_reg  <= rkey_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_ctrl.sv
`default_nettype none
// ====================================================================
// tb_aes_iter_ctrl -- directed scoreboard bench for aes_iter_ctrl.  Rev 1.0
// ====================================================================
module tb_aes_iter_ctrl;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] key, data, result;

   aes_iter_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .key       (key),
      .data      (data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] R1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] D2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] R2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] R0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic [127:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int acc    = 0;
   int acc1   = 0;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Present a request, wait for acceptance, then scramble key/data so late sampling shows up.
   task automatic send(input logic [127:0] k, input logic [127:0] d, input logic [127:0] r);
      int n = 0;
      key = k; data = d; in_valid = 1'b1;
      while (!in_ready && n < 40) begin
         step();
         n++;
      end
      chk("ready_wait", {127'd0, in_ready}, 128'd1);
      step();
      acc = cyc;
      exp_q.push_back(r);
      chk("busy_after_accept", {127'd0, busy}, 128'd1);
      in_valid = 1'b0;
      key  = {$urandom, $urandom, $urandom, $urandom};
      data = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      logic [127:0] e;
      while (!out_valid && n < 40) begin
         chk({tag, "_result_zero"}, result, 128'd0);
         step();
         n++;
      end
      chk({tag, "_latency"}, 128'(cyc - acc), 128'd10);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = 'x;
      chk({tag, "_result"}, result, e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; key = '0; data = '0;
      #1 rst = 1'b0;
      #12;
      chk("rst_in_ready",  {127'd0, in_ready},  128'd0);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_busy",      {127'd0, busy},      128'd0);
      chk("rst_result",    result,              128'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      step();
      chk("in_ready_after_release", {127'd0, in_ready}, 128'd1);

      // FIPS-197 C.1 vector; key/data are scrambled during RUN by send().
      send(K1, D1, R1);
      wait_out("fips_c1");
      step();
      chk("handshake_out_valid", {127'd0, out_valid}, 128'd0);
      chk("handshake_result",    result,              128'd0);
      chk("handshake_in_ready",  {127'd0, in_ready},  128'd1);

      send('0, '0, R0);
      wait_out("all_zero");
      step();

      // Stall in DONE with in_valid pulses that must be ignored.
      out_ready = 1'b0;
      send(K2, D2, R2);
      wait_out("stall");
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         key  = {$urandom, $urandom, $urandom, $urandom};
         data = {$urandom, $urandom, $urandom, $urandom};
         step();
         chk("stall_out_valid", {127'd0, out_valid}, 128'd1);
         chk("stall_result",    result,              R2);
         chk("stall_in_ready",  {127'd0, in_ready},  128'd0);
         chk("stall_busy",      {127'd0, busy},      128'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("stall_release_valid", {127'd0, out_valid}, 128'd0);
      chk("stall_release_busy",  {127'd0, busy},      128'd0);

      // Back-to-back: in_valid stays high with a second vector queued.
      key = K1; data = D1; in_valid = 1'b1;
      step();
      acc  = cyc;
      acc1 = cyc;
      exp_q.push_back(R1);
      key = K2; data = D2;
      wait_out("b2b_first");
      step();
      chk("b2b_in_ready", {127'd0, in_ready}, 128'd1);
      step();
      acc = cyc;
      exp_q.push_back(R2);
      in_valid = 1'b0;
      chk("b2b_spacing", 128'(acc - acc1), 128'd12);
      chk("b2b_busy",    {127'd0, busy},   128'd1);
      wait_out("b2b_second");
      step();

      // Abort in round 5 with an asynchronous reset pulse.
      send(K1, D1, R1);
      repeat (4) step();
      #2 rst = 1'b0;
      #1;
      chk("abort_busy",      {127'd0, busy},      128'd0);
      chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
      chk("abort_in_ready",  {127'd0, in_ready},  128'd0);
      chk("abort_result",    result,              128'd0);
      exp_q.delete();
      step();
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("abort_no_output", {127'd0, out_valid}, 128'd0);
      end
      chk("abort_in_ready_back", {127'd0, in_ready}, 128'd1);
      send(K1, D1, R1);
      wait_out("after_abort");
      step();
      chk("final_queue_empty", 128'(exp_q.size()), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
